// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the Harvard 5-instruction MIPS core front end.
//   fetch_state_t        : 2-bit sequencing state of the fetch unit
//   OP_RTYPE / FN_JR     : opcode/func pair that identifies JR
//   RESET_VECTOR_DEFAULT : first fetch address after reset
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [5:0]  OP_RTYPE             = 6'h00;
    localparam logic [5:0]  FN_JR                = 6'h08;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Avalon-style instruction-memory read bus.
//   instr_address     : byte address of the word being read
//   instr_read        : read strobe
//   instr_waitrequest : memory stall; a read completes on read=1, waitrequest=0
//   instr_readdata    : fetched word, valid when the read completes
// Modports: master (fetch unit), slave (instruction memory).
// -----------------------------------------------------------------------------
interface fetch_unit_if;

    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;

    modport master (
        output instr_address,
        output instr_read,
        input  instr_waitrequest,
        input  instr_readdata
    );

    modport slave (
        input  instr_address,
        input  instr_read,
        output instr_waitrequest,
        output instr_readdata
    );

endinterface

// File: rtl/fetch_unit_instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational field slicer for a 32-bit MIPS instruction word.
//   ir            in  : instruction register
//   opcode        out : ir[31:26]
//   rs, rt, rd    out : ir[25:21], ir[20:16], ir[15:11]
//   func_code     out : ir[5:0]
//   alu_immediate out : ir[15:0]
//   is_jr         out : R-type with func JR
// -----------------------------------------------------------------------------
module instr_decode
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  func_code,
    output logic [15:0] alu_immediate,
    output logic        is_jr
);

    assign opcode        = ir[31:26];
    assign rs            = ir[25:21];
    assign rt            = ir[20:16];
    assign rd            = ir[15:11];
    assign func_code     = ir[5:0];
    assign alu_immediate = ir[15:0];
    assign is_jr         = (ir[31:26] == OP_RTYPE) && (ir[5:0] == FN_JR);

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch and sequencing for the 5-instruction MIPS core. Owns the
// PC and the delay-slot next-PC, runs the instruction-memory read handshake,
// holds the instruction register and exposes its fields to the datapath.
// Execution stops when the address about to be fetched is 0.
//
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   imem (master)     : instruction-memory read bus (fetch_unit_if)
//   jr_target         : rs register value from the datapath, used by JR
//   opcode..alu_immediate : instruction-register fields
//   instr_valid       : high for the single EXEC cycle of each instruction
//   active            : low once halted
//   fault             : misaligned JR target seen (sticky until reset)
//
// Build option: FETCH_ALIGN_CHECK_EN -- when defined, a JR to a non-word-aligned
// target halts immediately (delay slot not executed) and raises fault. When
// undefined, the low two target bits are masked and fault is tied low.
// -----------------------------------------------------------------------------
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       imem,
    input  logic [31:0]        jr_target,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [5:0]         func_code,
    output logic [15:0]        alu_immediate,
    output logic               instr_valid,
    output logic               active,
    output logic               fault
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  npc_q, npc_d;
    logic [31:0]  ir_q, ir_d;
    logic         is_jr;
    logic         align_fault;
    logic [31:0]  jr_target_eff;
    logic         read_done;

    instr_decode u_decode (
        .ir            (ir_q),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .func_code     (func_code),
        .alu_immediate (alu_immediate),
        .is_jr         (is_jr)
    );

    assign read_done = (state_q == FETCH) && !imem.instr_waitrequest;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    // Only a JR actually executing can fault; the target is otherwise ignored.
    assign align_fault   = (state_q == EXEC) && is_jr && (jr_target[1:0] != 2'b00);
    assign jr_target_eff = jr_target;

    always_comb begin
        fault_d = fault_q | align_fault;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end

    assign fault = fault_q;
`else
    assign align_fault   = 1'b0;
    assign jr_target_eff = jr_target & 32'hFFFF_FFFC;
    assign fault         = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (read_done) state_d = EXEC;
            EXEC: begin
                // npc_q is the address that would be fetched next: 0 means stop.
                if (align_fault || (npc_q == 32'd0)) state_d = HALT;
                else                                 state_d = FETCH;
            end
            HALT:  state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem.instr_read = 1'b0;
        instr_valid     = 1'b0;
        active          = 1'b1;
        case (state_q)
            FETCH: imem.instr_read = 1'b1;
            EXEC:  instr_valid     = 1'b1;
            HALT:  active          = 1'b0;
            default: ;
        endcase
    end

    assign imem.instr_address = pc_q;

    // ---------------- PC / npc / IR ----------------
    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        ir_d  = ir_q;
        if (read_done) ir_d = imem.instr_readdata;
        // Delay-slot sequencing: the word after a JR always runs before the
        // target, because pc advances to the old npc, not to the target.
        if ((state_q == EXEC) && !align_fault) begin
            pc_d  = npc_q;
            npc_d = is_jr ? jr_target_eff : (npc_q + 32'd4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            npc_q <= RESET_VECTOR + 32'd4;
            ir_q  <= 32'd0;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
            ir_q  <= ir_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A responder task serves each fetch; the
// expected fetch address sequence of every program is queued up front and
// popped as the DUT issues reads.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] jr_target;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  func_code;
    logic [15:0] alu_immediate;
    logic        instr_valid, active, fault;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr[$];

    localparam logic [31:0] RV   = 32'hBFC00000;
    localparam logic [31:0] JR1  = 32'h00200008;  // jr $1
    localparam logic [31:0] ADDI = 32'h24210001;  // addiu $1,$1,1
    localparam logic [31:0] NOTJ = 32'h24010008;  // addiu, func bits look like JR
    localparam logic [31:0] NOP  = 32'h00000000;

    fetch_unit_if mem ();

    fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (mem),
        .jr_target     (jr_target),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .func_code     (func_code),
        .alu_immediate (alu_immediate),
        .instr_valid   (instr_valid),
        .active        (active),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    // Hold reset for two cycles; returns on the negedge where reset drops.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        mem.instr_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait (bounded) for a read, answer it with no stall, return in EXEC.
    task automatic serve_fetch(input logic [31:0] data, input logic [31:0] tgt,
                               output logic [31:0] addr, output bit ok, output int waited);
        waited = 0;
        ok     = 1'b0;
        addr   = 32'hxxxxxxxx;
        while (mem.instr_read !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (mem.instr_read !== 1'b1) return;
        addr = mem.instr_address;
        mem.instr_waitrequest = 1'b0;
        mem.instr_readdata    = data;
        jr_target             = tgt;
        @(negedge clk);
        ok = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] a; bit ok; int w;
        reset = 1'b1;
        mem.instr_waitrequest = 1'b0;
        mem.instr_readdata    = 32'd0;
        jr_target             = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem.instr_read !== 1'b0 || active !== 1'b1 || instr_valid !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: read=%b active=%b valid=%b fault=%b, want 0 1 0 0",
                     mem.instr_read, active, instr_valid, fault);
        end
        checks++;
        if ({opcode, rs, rt, rd, func_code, alu_immediate} !== '0 || mem.instr_address !== RV) begin
            errors++;
            $display("FAIL reset_fields: fields=%h addr=%h, want 0 and %h",
                     {opcode, rs, rt, rd, func_code, alu_immediate}, mem.instr_address, RV);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem.instr_read !== 1'b1 || mem.instr_address !== RV) begin
            errors++;
            $display("FAIL reset_first_fetch: read=%b addr=%h, want 1 %h", mem.instr_read, mem.instr_address, RV);
        end
        serve_fetch(ADDI, 32'd0, a, ok, w);
        checks++;
        if (!ok || instr_valid !== 1'b1 || w != 0) begin
            errors++;
            $display("FAIL reset_exec: ok=%b valid=%b waited=%0d, want 1 1 0", ok, instr_valid, w);
        end
    endtask

    task automatic test_wait();
        apply_reset();
        @(negedge clk);
        mem.instr_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem.instr_read !== 1'b1 || mem.instr_address !== RV || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold[%0d]: read=%b addr=%h valid=%b, want 1 %h 0",
                         i, mem.instr_read, mem.instr_address, instr_valid, RV);
            end
            if (i == 3) begin
                mem.instr_waitrequest = 1'b0;
                mem.instr_readdata    = ADDI;
            end
            @(negedge clk);
        end
        checks++;
        if (instr_valid !== 1'b1 || rs !== 5'd1) begin
            errors++;
            $display("FAIL wait_exec: valid=%b rs=%0d, want 1 1", instr_valid, rs);
        end
    endtask

    task automatic test_addiu();
        logic [31:0] a, e; bit ok; int w;
        apply_reset();
        for (int i = 0; i < 3; i++) exp_addr.push_back(RV + 32'(4 * i));
        for (int i = 0; i < 3; i++) begin
            serve_fetch(ADDI, 32'd0, a, ok, w);
            e = exp_addr.pop_front();
            checks++;
            if (!ok || a !== e || rs !== 5'd1 || rt !== 5'd1 || alu_immediate !== 16'h0001 ||
                instr_valid !== 1'b1 || opcode !== 6'h09) begin
                errors++;
                $display("FAIL addiu[%0d]: addr=%h rs=%0d rt=%0d imm=%h valid=%b op=%h, want %h 1 1 0001 1 09",
                         i, a, rs, rt, alu_immediate, instr_valid, opcode, e);
            end
            // Back-to-back instructions: exactly one FETCH cycle between EXECs.
            if (i > 0) begin
                checks++;
                if (w != 1) begin
                    errors++;
                    $display("FAIL addiu_rate[%0d]: waited=%0d, want 1", i, w);
                end
            end
        end
    endtask

    task automatic test_jr();
        logic [31:0] a, e; bit ok; int w;
        logic [31:0] words [7] = '{JR1, NOP, JR1, JR1, NOP, NOTJ, NOP};
        logic [31:0] tgts  [7] = '{32'h1000, 32'h0, 32'h2000, 32'h3000, 32'h0, 32'h5000, 32'h0};
        logic [31:0] addrs [7] = '{RV, RV + 32'd4, 32'h1000, 32'h1004, 32'h2000, 32'h3000, 32'h3004};
        apply_reset();
        foreach (addrs[i]) exp_addr.push_back(addrs[i]);
        for (int i = 0; i < 7; i++) begin
            serve_fetch(words[i], tgts[i], a, ok, w);
            e = exp_addr.pop_front();
            checks++;
            if (!ok || a !== e || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL jr_seq[%0d]: addr=%h valid=%b ok=%b, want %h 1 1", i, a, instr_valid, ok, e);
            end
        end
    endtask

    task automatic test_jr_zero();
        logic [31:0] a, e; bit ok; int w;
        apply_reset();
        exp_addr.push_back(RV);
        exp_addr.push_back(RV + 32'd4);
        serve_fetch(JR1, 32'd0, a, ok, w);
        e = exp_addr.pop_front();
        checks++;
        if (!ok || a !== e) begin
            errors++;
            $display("FAIL jrz_jr: addr=%h ok=%b, want %h", a, ok, e);
        end
        serve_fetch(ADDI, 32'h1234, a, ok, w);
        e = exp_addr.pop_front();
        checks++;
        if (!ok || a !== e || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL jrz_delay_slot: addr=%h valid=%b, want %h 1", a, instr_valid, e);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (active !== 1'b0 || mem.instr_read !== 1'b0 || instr_valid !== 1'b0 ||
                rs !== 5'd1 || alu_immediate !== 16'h0001) begin
                errors++;
                $display("FAIL jrz_halt[%0d]: active=%b read=%b valid=%b rs=%0d imm=%h, want 0 0 0 1 0001",
                         i, active, mem.instr_read, instr_valid, rs, alu_immediate);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a, e; bit ok; int w;
        logic [31:0] words [4] = '{JR1, NOP, NOP, NOP};
        logic [31:0] addrs [4] = '{RV, RV + 32'd4, 32'hFFFFFFF8, 32'hFFFFFFFC};
        apply_reset();
        foreach (addrs[i]) exp_addr.push_back(addrs[i]);
        for (int i = 0; i < 4; i++) begin
            serve_fetch(words[i], 32'hFFFFFFF8, a, ok, w);
            e = exp_addr.pop_front();
            checks++;
            if (!ok || a !== e) begin
                errors++;
                $display("FAIL wrap[%0d]: addr=%h ok=%b, want %h", i, a, ok, e);
            end
        end
        @(negedge clk);
        checks++;
        if (active !== 1'b0 || mem.instr_read !== 1'b0) begin
            errors++;
            $display("FAIL wrap_halt: active=%b read=%b, want 0 0", active, mem.instr_read);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] a; bit ok; int w;
        apply_reset();
        serve_fetch(ADDI, 32'd0, a, ok, w);
        @(negedge clk);
        mem.instr_waitrequest = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem.instr_read !== 1'b1 || mem.instr_address !== RV + 32'd4) begin
            errors++;
            $display("FAIL midfetch_pre: read=%b addr=%h, want 1 %h", mem.instr_read, mem.instr_address, RV + 32'd4);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem.instr_read !== 1'b0 || mem.instr_address !== RV || rs !== 5'd0 || alu_immediate !== 16'd0) begin
            errors++;
            $display("FAIL midfetch_reset: read=%b addr=%h rs=%0d imm=%h, want 0 %h 0 0000",
                     mem.instr_read, mem.instr_address, rs, alu_immediate, RV);
        end
        mem.instr_waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        serve_fetch(NOP, 32'd0, a, ok, w);
        checks++;
        if (!ok || a !== RV) begin
            errors++;
            $display("FAIL midfetch_refetch: addr=%h ok=%b, want %h", a, ok, RV);
        end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_align();
        logic [31:0] a; bit ok; int w;
        apply_reset();
        serve_fetch(JR1, 32'h00001002, a, ok, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (fault !== 1'b1 || active !== 1'b0 || mem.instr_read !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL align_halt[%0d]: fault=%b active=%b read=%b valid=%b, want 1 0 0 0",
                         i, fault, active, mem.instr_read, instr_valid);
            end
        end
        apply_reset();
        checks++;
        if (fault !== 1'b0 || active !== 1'b1) begin
            errors++;
            $display("FAIL align_reset: fault=%b active=%b, want 0 1", fault, active);
        end
        serve_fetch(NOP, 32'd0, a, ok, w);
        checks++;
        if (!ok || a !== RV) begin
            errors++;
            $display("FAIL align_refetch: addr=%h ok=%b, want %h", a, ok, RV);
        end
    endtask
`else
    task automatic test_mask();
        logic [31:0] a, e; bit ok; int w;
        logic [31:0] words [3] = '{JR1, NOP, NOP};
        logic [31:0] addrs [3] = '{RV, RV + 32'd4, 32'h00001000};
        apply_reset();
        foreach (addrs[i]) exp_addr.push_back(addrs[i]);
        for (int i = 0; i < 3; i++) begin
            serve_fetch(words[i], 32'h00001002, a, ok, w);
            e = exp_addr.pop_front();
            checks++;
            if (!ok || a !== e || fault !== 1'b0 || active !== 1'b1) begin
                errors++;
                $display("FAIL mask[%0d]: addr=%h fault=%b active=%b, want %h 0 1", i, a, fault, active, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wait();
        test_addiu();
        test_jr();
        test_jr_zero();
        test_wrap();
        test_reset_mid_fetch();
`ifdef FETCH_ALIGN_CHECK_EN
        test_align();
`else
        test_mask();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and sequencing stage directly upstream of the datapath in the Harvard 5-instruction MIPS core.
- Owns the PC, the next-PC with branch-delay-slot semantics, and the Avalon-style instruction-memory read handshake.
- Latches each fetched word into an instruction register and slices it into the rs/rt/rd/func_code/immediate fields the datapath consumes.
- Takes the JR target from the datapath's reg_read_data_0 and stops the CPU when execution jumps to address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- instr_address  out  32  instruction memory byte address (= pc).
- instr_read  out  1  read strobe.
- instr_waitrequest  in  1  memory stall; read completes on a cycle with instr_read=1 and instr_waitrequest=0.
- instr_readdata  in  32  fetched word, valid when the read completes.
- jr_target  in  32  rs register value from the datapath (reg_read_data_0).
- opcode  out  6  IR[31:26].
- rs  out  5  IR[25:21].
- rt  out  5  IR[20:16].
- rd  out  5  IR[15:11].
- func_code  out  6  IR[5:0].
- alu_immediate  out  16  IR[15:0].
- instr_valid  out  1  high only in EXEC; control gates RegWrite and data-memory strobes with it.
- active  out  1  CPU running; low once halted.
- fault  out  1  misaligned JR target (only with the optional feature; otherwise tied 0).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, reset).
- States: IDLE, FETCH, EXEC, HALT. The shared enum is 2 bits.
- Reset, applied immediately:
  - state=IDLE, pc=RESET_VECTOR, npc=RESET_VECTOR+4, IR=0.
  - All field outputs are 0. instr_read=0, instr_valid=0, active=1, fault=0.
- IDLE: next cycle goes to FETCH unconditionally.
- FETCH:
  - instr_read=1 and instr_address=pc, both held stable while instr_waitrequest=1.
  - On the cycle with waitrequest=0: IR<=instr_readdata and state goes to EXEC.
  - Minimum latency is 1 cycle in FETCH plus 1 cycle in EXEC (2 cycles per instruction).
- EXEC:
  - instr_read=0, instr_valid=1, and the fields are driven from IR.
  - The datapath completes the instruction this cycle; the register write happens at the closing edge.
  - Update at the edge: pc<=npc; npc<= is_jr ? jr_target : npc+4.
  - is_jr is defined as opcode==6'h00 && func_code==6'h08.
  - If npc==0 at this edge (the address about to be fetched is 0), state goes to HALT. Otherwise it goes to FETCH.
  - Consequence: JR to 0 still executes its delay slot, then halts.
- HALT: terminal until reset. active=0, instr_read=0, instr_valid=0, and the fields keep their last IR value.
- Arithmetic:
  - npc+4 is a 32-bit add with wrap-around; 32'hFFFFFFFC+4 gives 0, which halts.
  - jr_target is sampled only at the EXEC edge.
- Reset mid-FETCH (even with waitrequest=1) drops the read immediately. The next read starts at RESET_VECTOR.
- A JR sitting in the delay slot of another JR follows the standard chain: the second target is taken after the first target's instruction.
- Without the macro, jr_target[1:0] are cleared before use.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - In EXEC, if is_jr and jr_target[1:0]!=0, state goes to HALT at that edge. The delay slot is not executed.
  - fault=1 (sticky until reset) and active=0.
- Undefined:
  - Low two bits are masked.
  - fault is tied to 0 and no fault path is synthesised.

Decomposition:
- Package mips_pkg holds:
  - typedef enum logic[1:0] fetch_state_t {IDLE, FETCH, EXEC, HALT}.
  - Constants OP_RTYPE=6'h00, FN_JR=6'h08, RESET_VECTOR_DEFAULT=32'hBFC00000.
- One natural combinational sub-module, instr_decode: IR in, field slices plus is_jr out. It can be reused by the control unit.
- PC/npc registers and the FSM stay in fetch_unit.

Test Plan:
1. Reset pulse, waitrequest=0:
   - During reset, instr_read=0 and active=1.
   - One cycle after release, instr_read=1 with instr_address=32'hBFC00000.
   - EXEC follows on the next cycle.
2. Hold waitrequest=1 for 3 cycles on the first fetch:
   - instr_address stays at BFC00000 and instr_read stays 1 for all 4 FETCH cycles.
   - instr_valid rises exactly one cycle after waitrequest drops.
3. Feed ADDIU 0x24210001 three times:
   - Fetch addresses are BFC00000, BFC00004, BFC00008.
   - rs=1, rt=1, alu_immediate=16'h0001, instr_valid pulses every 2nd cycle.
4. JR $1 (0x00200008) with jr_target=32'h00001000:
   - Next fetches are BFC00004 (delay slot), then 00001000.
5. JR with jr_target=0:
   - The delay slot at +4 is fetched and gets instr_valid.
   - Then active=0, instr_read=0 permanently, and no further addresses appear.
6. With FETCH_ALIGN_CHECK_EN, JR with jr_target=32'h00001002:
   - Immediate HALT with fault=1 and no delay-slot fetch.
   - A subsequent reset clears fault and refetches BFC00000.
